// File: rtl/ahb2apb_mux_bridge_if.sv
// Bus interfaces for the AHB-Lite to multi-slave APB3 bridge.
//   ahb_lite_if : AHB-Lite slave port (master = interconnect, slave = bridge)
//   apb_mux_if  : shared APB3 bus    (master = bridge, slave = peripherals)
interface ahb_lite_if #(
  parameter int ADDR_W = 32
);
  logic              HSEL;
  logic [ADDR_W-1:0] HADDR;
  logic [1:0]        HTRANS;
  logic              HWRITE;
  logic [31:0]       HWDATA;
  logic              HREADY;
  logic [31:0]       HRDATA;
  logic              HREADYOUT;
  logic [1:0]        HRESP;

  modport master (output HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
                  input  HRDATA, HREADYOUT, HRESP);
  modport slave  (input  HSEL, HADDR, HTRANS, HWRITE, HWDATA, HREADY,
                  output HRDATA, HREADYOUT, HRESP);
endinterface

interface apb_mux_if #(
  parameter int ADDR_W  = 32,
  parameter int NUM_SLV = 4
);
  logic [NUM_SLV-1:0]    PSEL;
  logic                  PENABLE;
  logic [ADDR_W-1:0]     PADDR;
  logic                  PWRITE;
  logic [31:0]           PWDATA;
  logic [32*NUM_SLV-1:0] PRDATA;
  logic [NUM_SLV-1:0]    PREADY;
  logic [NUM_SLV-1:0]    PSLVERR;

  modport master (output PSEL, PENABLE, PADDR, PWRITE, PWDATA,
                  input  PRDATA, PREADY, PSLVERR);
  modport slave  (input  PSEL, PENABLE, PADDR, PWRITE, PWDATA,
                  output PRDATA, PREADY, PSLVERR);
endinterface

// File: rtl/ahb2apb_mux_bridge.sv
// AHB-Lite slave to multi-slave APB3 bridge. One APB access in flight at a
// time; slave picked by HADDR[SLV_LSB +: SLV_IDX_W]; out-of-range index and
// PSLVERR both give a two-cycle AHB ERROR response.
// Optional: define APB_TIMEOUT_EN to bound the ACCESS phase to TIMEOUT_CYC.

// Per-slave slice: select decode and AND-gating of the slave's response so
// the top can OR-reduce the returns into a single mux.
module ahb2apb_slv_slice #(
  parameter int SLV_IDX_W = 2,
  parameter int ID        = 0
) (
  input  logic [SLV_IDX_W-1:0] idx,
  input  logic                 sel_en,
  input  logic [31:0]          prdata,
  input  logic                 pready,
  input  logic                 pslverr,
  output logic                 psel,
  output logic [31:0]          rdata,
  output logic                 ready,
  output logic                 err
);
  logic hit;
  assign hit   = (idx == SLV_IDX_W'(ID));
  assign psel  = sel_en & hit;
  assign rdata = hit ? prdata : '0;
  assign ready = hit & pready;
  assign err   = hit & pslverr;
endmodule

module ahb2apb_mux_bridge #(
  parameter int ADDR_W      = 32,
  parameter int NUM_SLV     = 4,
  parameter int SLV_LSB     = 12,
  parameter int TIMEOUT_CYC = 256
) (
  input  logic       HCLK,
  input  logic       HRESETN,
  ahb_lite_if.slave  ahb,
  apb_mux_if.master  apb
);
  localparam int SLV_IDX_W = (NUM_SLV > 1) ? $clog2(NUM_SLV) : 1;

  localparam logic [2:0] ST_IDLE   = 3'd0;
  localparam logic [2:0] ST_WDATA  = 3'd1;
  localparam logic [2:0] ST_SETUP  = 3'd2;
  localparam logic [2:0] ST_ACCESS = 3'd3;
  localparam logic [2:0] ST_ERR1   = 3'd4;
  localparam logic [2:0] ST_ERR2   = 3'd5;

  logic [2:0]              state_q, state_d, accept_st;
  logic [SLV_IDX_W-1:0]    idx_q, hidx;
  logic [ADDR_W-1:0]       paddr_q;
  logic                    pwrite_q;
  logic [31:0]             pwdata_q;
  logic                    accept, bad_idx, hready_out, resp_err;
  logic                    sel_en, in_access, sel_ready, sel_err;
  logic                    acc_ok, acc_err, timeout_hit;
  logic [31:0]             sel_rdata;
  logic [NUM_SLV-1:0]      psel_w, ready_g, err_g;
  logic [NUM_SLV-1:0][31:0] rdata_g;
  logic                    unused_htrans0;

  assign unused_htrans0 = ahb.HTRANS[0];

  // Address decode of the incoming address phase
  assign hidx      = ahb.HADDR[SLV_LSB +: SLV_IDX_W];
  assign bad_idx   = ({1'b0, hidx} >= (SLV_IDX_W+1)'(NUM_SLV));
  assign accept    = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1] & hready_out;
  assign accept_st = bad_idx ? ST_ERR1 : (ahb.HWRITE ? ST_WDATA : ST_SETUP);

  assign sel_en    = (state_q == ST_SETUP) | (state_q == ST_ACCESS);
  assign in_access = (state_q == ST_ACCESS);

  for (genvar gi = 0; gi < NUM_SLV; gi++) begin : g_slv
    ahb2apb_slv_slice #(.SLV_IDX_W(SLV_IDX_W), .ID(gi)) u_slv (
      .idx     (idx_q),
      .sel_en  (sel_en),
      .prdata  (apb.PRDATA[32*gi +: 32]),
      .pready  (apb.PREADY[gi]),
      .pslverr (apb.PSLVERR[gi]),
      .psel    (psel_w[gi]),
      .rdata   (rdata_g[gi]),
      .ready   (ready_g[gi]),
      .err     (err_g[gi])
    );
  end

  // OR-reduce the gated slave returns (only the selected slice is non-zero)
  always_comb begin
    sel_rdata = '0;
    for (int i = 0; i < NUM_SLV; i++) sel_rdata = sel_rdata | rdata_g[i];
  end
  assign sel_ready = |ready_g;
  assign sel_err   = |err_g;

  assign acc_ok  = in_access & sel_ready & ~sel_err;
  assign acc_err = in_access & sel_ready & sel_err;

`ifdef APB_TIMEOUT_EN
  localparam int TO_W = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;
  logic [TO_W-1:0] to_cnt_q;

  // Count ACCESS cycles spent waiting on PREADY; restart on every SETUP
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN)                    to_cnt_q <= '0;
    else if (state_q == ST_SETUP)    to_cnt_q <= '0;
    else if (in_access & ~sel_ready) to_cnt_q <= to_cnt_q + 1'b1;
  end
  assign timeout_hit = in_access & ~sel_ready & (to_cnt_q == TO_W'(TIMEOUT_CYC-1));
`else
  localparam int unused_timeout_cyc = TIMEOUT_CYC;
  assign timeout_hit = 1'b0;
`endif

  // AHB response: ready in IDLE/ERR2/good completion, ERROR through the error path
  always_comb begin
    hready_out = (state_q == ST_IDLE) | (state_q == ST_ERR2) | acc_ok;
    resp_err   = (state_q == ST_ERR1) | (state_q == ST_ERR2) | acc_err;
  end

  // Next-state: completion cycles chain straight into a newly accepted transfer
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE:   if (accept) state_d = accept_st;
      ST_WDATA:  state_d = ST_SETUP;
      ST_SETUP:  state_d = ST_ACCESS;
      ST_ACCESS: begin
        if (acc_err | timeout_hit) state_d = ST_ERR1;
        else if (acc_ok)           state_d = accept ? accept_st : ST_IDLE;
      end
      ST_ERR1:   state_d = ST_ERR2;
      ST_ERR2:   state_d = accept ? accept_st : ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // State register
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) state_q <= ST_IDLE;
    else          state_q <= state_d;
  end

  // Address-phase capture; APB address/direction hold until the next accept
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN) begin
      idx_q    <= '0;
      paddr_q  <= '0;
      pwrite_q <= 1'b0;
    end else if (accept) begin
      idx_q    <= hidx;
      paddr_q  <= ahb.HADDR;
      pwrite_q <= ahb.HWRITE;
    end
  end

  // Write data is only valid in the AHB data phase, so grab it in WDATA
  always_ff @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN)                 pwdata_q <= '0;
    else if (state_q == ST_WDATA) pwdata_q <= ahb.HWDATA;
  end

  assign ahb.HREADYOUT = hready_out;
  assign ahb.HRESP     = {1'b0, resp_err};
  assign ahb.HRDATA    = acc_ok ? sel_rdata : '0;

  assign apb.PSEL      = psel_w;
  assign apb.PENABLE   = in_access;
  assign apb.PADDR     = paddr_q;
  assign apb.PWRITE    = pwrite_q;
  assign apb.PWDATA    = pwdata_q;
endmodule

// File: tb/tb_ahb2apb_mux_bridge.sv
// Directed bench for ahb2apb_mux_bridge. Five slaves so that indices 5..7
// are decodable but out of range. Expectations are queued at address phase
// and checked by a negedge monitor when the data phase completes.
module tb_ahb2apb_mux_bridge;
  localparam int NSLV = 5;

  typedef struct {
    logic [31:0]     addr;
    logic            wr;
    logic [31:0]     wdata;
    logic [1:0]      resp;
    logic [31:0]     rdata;
    int              lat;
    logic [NSLV-1:0] psel;
    int              npsel;
    int              nerr;
  } exp_t;

  logic HCLK, HRESETN;
  int   tests = 0, fails = 0;
  int   wait_cfg = 0, acc_cnt;
  logic err_cfg = 1'b0;
  exp_t exp_q[$];
  exp_t cur;
  bit   dphase = 0;
  int   lat, npsel, nerr;

  ahb_lite_if #(.ADDR_W(32)) ahb ();
  apb_mux_if  #(.ADDR_W(32), .NUM_SLV(NSLV)) apb ();

  ahb2apb_mux_bridge #(.ADDR_W(32), .NUM_SLV(NSLV), .SLV_LSB(12), .TIMEOUT_CYC(4)) dut (
    .HCLK    (HCLK),
    .HRESETN (HRESETN),
    .ahb     (ahb),
    .apb     (apb)
  );

  initial HCLK = 1'b0;
  always #5 HCLK = ~HCLK;

  // Single-slave system: bus HREADY is our own HREADYOUT
  assign ahb.HREADY  = ahb.HREADYOUT;
  assign apb.PRDATA  = {32'hE4E40004, 32'hD00D0003, 32'hCAFE0001, 32'hB0B00001, 32'hA5A50000};
  assign apb.PREADY  = (acc_cnt >= wait_cfg) ? {NSLV{1'b1}} : '0;
  assign apb.PSLVERR = err_cfg ? {NSLV{1'b1}} : '0;

  // Slave model: PREADY rises after wait_cfg ACCESS cycles
  always @(posedge HCLK or negedge HRESETN) begin
    if (!HRESETN)                             acc_cnt <= 0;
    else if (apb.PENABLE && !apb.PREADY[0])   acc_cnt <= acc_cnt + 1;
    else                                      acc_cnt <= 0;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t mk(logic [31:0] a, logic wr, logic [31:0] wd, logic [1:0] resp,
                              logic [31:0] rd, int lt, logic [NSLV-1:0] ps, int nps, int ne);
    exp_t e;
    e.addr = a; e.wr = wr; e.wdata = wd; e.resp = resp; e.rdata = rd;
    e.lat = lt; e.psel = ps; e.npsel = nps; e.nerr = ne;
    return e;
  endfunction

  // Drive one address phase (caller is at posedge+1), hold until accepted
  task automatic addr_phase(input exp_t e);
    bit acc = 0;
    ahb.HSEL = 1'b1; ahb.HTRANS = 2'b10; ahb.HADDR = e.addr; ahb.HWRITE = e.wr;
    exp_q.push_back(e);
    for (int n = 0; n < 200 && !acc; n++) begin
      @(negedge HCLK); acc = ahb.HREADYOUT;
      @(posedge HCLK);
    end
    check("addr_accept", {31'd0, acc}, 32'd1);
    #1;
    ahb.HSEL = 1'b0; ahb.HTRANS = 2'b00; ahb.HWDATA = e.wdata;
  endtask

  task automatic wait_done();
    for (int n = 0; n < 200 && exp_q.size() != 0; n++) @(negedge HCLK);
    check("drain", exp_q.size(), 32'd0);
    @(posedge HCLK); #1;
  endtask

  // Data-phase monitor / scoreboard
  always @(negedge HCLK) begin
    if (!HRESETN) begin
      dphase = 0;
      exp_q.delete();
    end else begin
      if (dphase && exp_q.size() > 0) begin
        cur = exp_q[0];
        lat++;
        if (ahb.HRESP == 2'b01) nerr++;
        if (apb.PSEL != '0) begin
          check("psel", apb.PSEL, cur.psel);
          check("penable", apb.PENABLE, npsel > 0);
          check("paddr", apb.PADDR, cur.addr);
          check("pwrite", apb.PWRITE, cur.wr);
          if (cur.wr) check("pwdata", apb.PWDATA, cur.wdata);
          npsel++;
        end
        if (ahb.HREADYOUT) begin
          check("hresp", ahb.HRESP, cur.resp);
          if (!cur.wr) check("hrdata", ahb.HRDATA, cur.rdata);
          check("latency", lat, cur.lat);
          check("psel_cycles", npsel, cur.npsel);
          check("err_cycles", nerr, cur.nerr);
          void'(exp_q.pop_front());
          dphase = 0;
        end else begin
          check("hrdata_wait", ahb.HRDATA, 32'd0);
        end
      end
      if (ahb.HSEL && ahb.HTRANS[1] && ahb.HREADYOUT) begin
        dphase = 1; lat = 0; npsel = 0; nerr = 0;
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    HRESETN = 1'b0;
    ahb.HSEL = 1'b0; ahb.HADDR = '0; ahb.HTRANS = 2'b00; ahb.HWRITE = 1'b0; ahb.HWDATA = '0;
    repeat (2) @(posedge HCLK);
    #1;
    check("rst_psel", apb.PSEL, 32'd0);
    check("rst_penable", apb.PENABLE, 32'd0);
    check("rst_paddr", apb.PADDR, 32'd0);
    check("rst_pwrite", apb.PWRITE, 32'd0);
    check("rst_pwdata", apb.PWDATA, 32'd0);
    check("rst_hreadyout", ahb.HREADYOUT, 32'd1);
    check("rst_hresp", ahb.HRESP, 32'd0);
    check("rst_hrdata", ahb.HRDATA, 32'd0);
    HRESETN = 1'b1;
    @(posedge HCLK); #1;

    // zero-wait read of slave 2
    addr_phase(mk(32'h2004, 0, 0, 2'b00, 32'hCAFE0001, 2, 5'b00100, 2, 0));
    wait_done();

    // write to slave 1 with 3 PREADY-low cycles
    wait_cfg = 3;
    addr_phase(mk(32'h1010, 1, 32'h12345678, 2'b00, 0, 6, 5'b00010, 5, 0));
    wait_done();
    wait_cfg = 0;

    // read slave 0 answered with PSLVERR
    err_cfg = 1'b1;
    addr_phase(mk(32'h0008, 0, 0, 2'b01, 0, 4, 5'b00001, 2, 3));
    wait_done();
    err_cfg = 1'b0;

    // out-of-range index 5: no PSEL, two-cycle ERROR
    addr_phase(mk(32'h5000, 0, 0, 2'b01, 0, 2, 5'b00000, 0, 2));
    wait_done();

    // highest valid index
    addr_phase(mk(32'h4000, 0, 0, 2'b00, 32'hE4E40004, 2, 5'b10000, 2, 0));
    wait_done();

    // back-to-back NONSEQ: slave 0 then slave 3, no idle cycle between
    addr_phase(mk(32'h0000, 0, 0, 2'b00, 32'hA5A50000, 2, 5'b00001, 2, 0));
    addr_phase(mk(32'h3000, 0, 0, 2'b00, 32'hD00D0003, 2, 5'b01000, 2, 0));
    wait_done();

    // long PREADY stall on slave 1
    wait_cfg = 12;
`ifdef APB_TIMEOUT_EN
    addr_phase(mk(32'h1000, 0, 0, 2'b01, 0, 7, 5'b00010, 5, 2));
`else
    addr_phase(mk(32'h1000, 0, 0, 2'b00, 32'hB0B00001, 14, 5'b00010, 14, 0));
`endif
    wait_done();
    wait_cfg = 0;
    check("hold_pwdata", apb.PWDATA, 32'h12345678);
    check("hold_paddr", apb.PADDR, 32'h1000);
    check("idle_psel", apb.PSEL, 32'd0);

    // reset in the middle of an ACCESS stall
    wait_cfg = 50;
    addr_phase(mk(32'h2000, 0, 0, 2'b00, 0, 0, 5'b00100, 0, 0));
    repeat (3) @(negedge HCLK);
    HRESETN = 1'b0;
    #1;
    check("midrst_psel", apb.PSEL, 32'd0);
    check("midrst_penable", apb.PENABLE, 32'd0);
    check("midrst_hreadyout", ahb.HREADYOUT, 32'd1);
    check("midrst_hresp", ahb.HRESP, 32'd0);
    check("midrst_paddr", apb.PADDR, 32'd0);
    check("midrst_pwdata", apb.PWDATA, 32'd0);
    @(negedge HCLK); #1;
    HRESETN = 1'b1;
    wait_cfg = 0;
    @(posedge HCLK); #1;

    // recovery read after reset
    addr_phase(mk(32'h2004, 0, 0, 2'b00, 32'hCAFE0001, 2, 5'b00100, 2, 0));
    wait_done();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
